dmem_request_unit: RTL and testbench

- MEM-stage data-memory request sequencer; sits between the EX/MEM latch and the data-side cache port.
- Downstream of the hazard detection unit. It turns a one-shot load/store in EX/MEM into a held request, waits for dhit, returns load data to MEM/WB, and drives mem_stall so the hazard unit freezes the pipe.
- Includes a wait watchdog with a sticky error flag.

---
 rtl/dmem_request_unit.sv | 145 ++++++++++++++
 tb/tb_dmem_request_unit.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/dmem_request_unit.sv
// MEM-stage data-memory request sequencer: holds a load/store toward the cache until dhit.
// Build option: define DMEM_LLSC_EN to add load-linked / store-conditional support.
module dmem_request_unit #(
    parameter int WORD_W   = 32,
    parameter int MAX_WAIT = 255
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              exmem_valid,
    input  logic              exmem_dREN,
    input  logic              exmem_dWEN,
    input  logic [WORD_W-1:0] exmem_addr,
    input  logic [WORD_W-1:0] exmem_store,
`ifdef DMEM_LLSC_EN
    input  logic              exmem_ll,
    input  logic              exmem_sc,
`endif
    input  logic              dhit,
    input  logic [WORD_W-1:0] dload,
    output logic              dmemREN,
    output logic              dmemWEN,
    output logic [WORD_W-1:0] dmemaddr,
    output logic [WORD_W-1:0] dmemstore,
    output logic              mem_stall,
    output logic [WORD_W-1:0] load_data,
    output logic              load_valid,
    output logic              timeout_err,
    output logic [1:0]        fsm_state
);

    localparam int CNT_W = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_WAIT);
    localparam logic [CNT_W-1:0] MAX_M1  = CNT_W'(MAX_WAIT - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] wait_cnt;
    logic             want_rd;
    logic             want_wr;
    logic             sc_fail;
    logic             new_req;

`ifdef DMEM_LLSC_EN
    logic              link_valid;
    logic [WORD_W-3:0] link_addr;
    logic              is_ll;
    logic              is_sc;
    logic              link_hit;

    assign want_rd  = exmem_dREN | exmem_ll;
    assign want_wr  = exmem_dWEN | exmem_sc;
    assign link_hit = link_valid && (exmem_addr[WORD_W-1:2] == link_addr);
    assign sc_fail  = exmem_sc & ~link_hit;
`else
    assign want_rd  = exmem_dREN;
    assign want_wr  = exmem_dWEN;
    assign sc_fail  = 1'b0;
`endif

    // Handshake: a request is held on dmemREN/dmemWEN from issue until the cycle dhit is
    // seen in BUSY; dhit in any other state is ignored. mem_stall covers issue and wait.
    assign new_req   = exmem_valid & (want_rd | want_wr);
    assign mem_stall = ((state == IDLE) && new_req) || (state == BUSY);
    assign fsm_state = state;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state       <= IDLE;
            dmemREN     <= 1'b0;
            dmemWEN     <= 1'b0;
            dmemaddr    <= '0;
            dmemstore   <= '0;
            load_data   <= '0;
            load_valid  <= 1'b0;
            timeout_err <= 1'b0;
            wait_cnt    <= '0;
`ifdef DMEM_LLSC_EN
            link_valid  <= 1'b0;
            link_addr   <= '0;
            is_ll       <= 1'b0;
            is_sc       <= 1'b0;
`endif
        end else begin
            load_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (new_req) begin
                        if (sc_fail) begin
                            load_data  <= '0;
                            load_valid <= 1'b1;
                            state      <= DONE;
                        end else begin
                            dmemaddr  <= exmem_addr;
                            dmemstore <= exmem_store;
                            dmemWEN   <= want_wr;
                            dmemREN   <= want_rd & ~want_wr;
                            state     <= BUSY;
`ifdef DMEM_LLSC_EN
                            is_ll     <= exmem_ll & ~want_wr;
                            is_sc     <= exmem_sc;
`endif
                        end
                    end
                end
                BUSY: begin
                    if (dhit) begin
                        dmemREN  <= 1'b0;
                        dmemWEN  <= 1'b0;
                        wait_cnt <= '0;
                        state    <= DONE;
                        if (dmemREN) begin
                            load_data  <= dload;
                            load_valid <= 1'b1;
                        end
`ifdef DMEM_LLSC_EN
                        if (is_ll) begin
                            link_valid <= 1'b1;
                            link_addr  <= dmemaddr[WORD_W-1:2];
                        end
                        if (dmemWEN && link_valid && (dmemaddr[WORD_W-1:2] == link_addr))
                            link_valid <= 1'b0;
                        if (is_sc) begin
                            load_data  <= WORD_W'(1);
                            load_valid <= 1'b1;
                        end
`endif
                    end else begin
                        // Watchdog only flags; the request keeps waiting for dhit.
                        if (wait_cnt != MAX_CNT)
                            wait_cnt <= wait_cnt + 1'b1;
                        if (wait_cnt >= MAX_M1)
                            timeout_err <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_request_unit.sv
// Self-checking bench for dmem_request_unit: directed cases plus random transactions
// against a transaction-level model (latency, link register and sticky watchdog).
module tb_dmem_request_unit;
  localparam int W    = 32;
  localparam int MAXW = 4;

  logic         CLK = 1'b0;
  logic         RST;
  logic         exmem_valid, exmem_dREN, exmem_dWEN;
  logic [W-1:0] exmem_addr, exmem_store;
  logic         exmem_ll, exmem_sc;
  logic         dhit;
  logic [W-1:0] dload;
  logic         dmemREN, dmemWEN, mem_stall, load_valid, timeout_err;
  logic [W-1:0] dmemaddr, dmemstore, load_data;
  logic [1:0]   fsm_state;

  dmem_request_unit #(.WORD_W(W), .MAX_WAIT(MAXW)) dut (
    .CLK(CLK), .RST(RST),
    .exmem_valid(exmem_valid), .exmem_dREN(exmem_dREN), .exmem_dWEN(exmem_dWEN),
    .exmem_addr(exmem_addr), .exmem_store(exmem_store),
`ifdef DMEM_LLSC_EN
    .exmem_ll(exmem_ll), .exmem_sc(exmem_sc),
`endif
    .dhit(dhit), .dload(dload),
    .dmemREN(dmemREN), .dmemWEN(dmemWEN), .dmemaddr(dmemaddr), .dmemstore(dmemstore),
    .mem_stall(mem_stall), .load_data(load_data), .load_valid(load_valid),
    .timeout_err(timeout_err), .fsm_state(fsm_state)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state: last completed read value, sticky watchdog, link register.
  logic [W-1:0] m_load = '0;
  logic         m_to   = 1'b0;
  logic         m_lv   = 1'b0;
  logic [29:0]  m_laddr = '0;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic bubble_inputs();
    exmem_valid = 1'b0; exmem_dREN = 1'b0; exmem_dWEN = 1'b0;
    exmem_ll = 1'b0; exmem_sc = 1'b0;
  endtask

  // Called #1 after a rising edge with the unit in IDLE. lat = BUSY cycle on which dhit arrives.
  task automatic do_txn(input logic valid, input logic ren, input logic wen,
                        input logic ll, input logic sc, input logic [W-1:0] addr,
                        input logic [W-1:0] store, input int lat, input logic [W-1:0] rdata);
    logic is_rd, is_wr, req, scf, exp_lv;
    is_rd = (ren | ll) & ~(wen | sc);
    is_wr = wen | sc;
    req   = valid & (is_rd | is_wr);
    scf   = valid & sc & ~(m_lv && (addr[31:2] == m_laddr));
    exmem_valid = valid; exmem_dREN = ren; exmem_dWEN = wen;
    exmem_ll = ll; exmem_sc = sc; exmem_addr = addr; exmem_store = store;
    dhit = 1'b0;
    #1;
    check("idle_stall", {31'd0, mem_stall}, {31'd0, req});
    check("idle_no_req", {30'd0, dmemREN, dmemWEN}, '0);
    if (!req) begin
      dhit = 1'b1; dload = $urandom;
      @(posedge CLK); #1;
      dhit = 1'b0;
      check("bubble_req", {30'd0, dmemREN, dmemWEN}, '0);
      check("bubble_stall", {31'd0, mem_stall}, '0);
      check("bubble_lv", {31'd0, load_valid}, '0);
      check("bubble_ld", load_data, m_load);
      bubble_inputs();
      return;
    end
    @(posedge CLK); #1;
    if (scf) begin
      m_load = '0;
      exp_lv = 1'b1;
    end else begin
      for (int i = 1; i <= lat; i++) begin
        if (i - 1 >= MAXW) m_to = 1'b1;
        check("busy_ren", {31'd0, dmemREN}, {31'd0, is_rd});
        check("busy_wen", {31'd0, dmemWEN}, {31'd0, is_wr});
        check("busy_addr", dmemaddr, addr);
        check("busy_store", dmemstore, store);
        check("busy_stall", {31'd0, mem_stall}, 32'd1);
        check("busy_lv", {31'd0, load_valid}, '0);
        check("busy_timeout", {31'd0, timeout_err}, {31'd0, m_to});
        if (i == lat) begin dhit = 1'b1; dload = rdata; end
        @(posedge CLK); #1;
        dhit = 1'b0;
      end
      exp_lv = is_rd;
      if (is_rd) m_load = rdata;
      if (ll && is_rd) begin m_lv = 1'b1; m_laddr = addr[31:2]; end
      if (sc) begin m_load = 32'd1; exp_lv = 1'b1; end
      if (is_wr && m_lv && (addr[31:2] == m_laddr)) m_lv = 1'b0;
    end
    check("done_stall", {31'd0, mem_stall}, '0);
    check("done_req", {30'd0, dmemREN, dmemWEN}, '0);
    check("done_lv", {31'd0, load_valid}, {31'd0, exp_lv});
    check("done_ld", load_data, m_load);
    check("done_timeout", {31'd0, timeout_err}, {31'd0, m_to});
    @(posedge CLK); #1;
    bubble_inputs();
    check("after_lv", {31'd0, load_valid}, '0);
    check("after_req", {30'd0, dmemREN, dmemWEN}, '0);
    check("after_ld", load_data, m_load);
  endtask

  initial begin
    RST = 1'b1; dhit = 1'b0; dload = '0;
    exmem_addr = '0; exmem_store = '0;
    bubble_inputs();
    #2;
    check("rst_async_ren", {31'd0, dmemREN}, '0);
    repeat (2) @(posedge CLK);
    #1;
    check("rst_req", {30'd0, dmemREN, dmemWEN}, '0);
    check("rst_addr", dmemaddr, '0);
    check("rst_store", dmemstore, '0);
    check("rst_ld", load_data, '0);
    check("rst_lv_to", {30'd0, load_valid, timeout_err}, '0);
    check("rst_stall", {31'd0, mem_stall}, '0);
    RST = 1'b0;
    @(posedge CLK); #1;

    // Directed: load hit, write-wins, bubble, store 5-cycle miss (crosses the watchdog).
    do_txn(1, 1, 0, 0, 0, 32'h0000_0040, 32'h0, 1, 32'hDEAD_BEEF);
    do_txn(1, 1, 1, 0, 0, 32'h0000_0080, 32'hA5A5_0001, 2, 32'h1111_2222);
    do_txn(0, 1, 0, 0, 0, 32'h0000_00C0, 32'h0, 1, 32'h0);
    do_txn(1, 0, 1, 0, 0, 32'h0000_0100, 32'h1234_5678, 5, 32'h0);
    check("timeout_sticky", {31'd0, timeout_err}, 32'd1);

    // Reset in the middle of a read wait.
    exmem_valid = 1'b1; exmem_dREN = 1'b1; exmem_addr = 32'h0000_0300;
    @(posedge CLK); #1;
    @(posedge CLK); #1;
    check("rb_ren_before", {31'd0, dmemREN}, 32'd1);
    bubble_inputs();
    #2 RST = 1'b1;
    #1;
    check("rb_ren_async", {31'd0, dmemREN}, '0);
    check("rb_stall", {31'd0, mem_stall}, '0);
    check("rb_timeout", {31'd0, timeout_err}, '0);
    m_to = 1'b0; m_load = '0; m_lv = 1'b0;
    @(posedge CLK); #1;
    RST = 1'b0;
    repeat (2) begin
      @(posedge CLK); #1;
      check("rb_idle_lv", {31'd0, load_valid}, '0);
      check("rb_idle_req", {30'd0, dmemREN, dmemWEN}, '0);
    end

    // Random plain loads/stores/bubbles.
    for (int t = 0; t < 24; t++) begin
      do_txn(($urandom_range(0, 3) != 0), $urandom_range(0, 1), $urandom_range(0, 1), 0, 0,
             $urandom, $urandom, $urandom_range(1, 3), $urandom);
    end
    check("rand_no_timeout", {31'd0, timeout_err}, '0);

    // Watchdog: long wait then a normal hit; flag stays set.
    do_txn(1, 1, 0, 0, 0, 32'h0000_0400, 32'h0, 7, 32'hCAFE_F00D);
    do_txn(1, 1, 0, 0, 0, 32'h0000_0404, 32'h0, 1, 32'h0BAD_CAFE);
    check("timeout_held", {31'd0, timeout_err}, 32'd1);

`ifdef DMEM_LLSC_EN
    // LL then SC succeeds; LL, plain store to the link, SC fails without a request.
    do_txn(1, 0, 0, 1, 0, 32'h0000_0200, 32'h0, 1, 32'h7777_0000);
    do_txn(1, 0, 0, 0, 1, 32'h0000_0200, 32'h5555_AAAA, 2, 32'h0);
    check("sc_ok_ld", load_data, 32'd1);
    do_txn(1, 0, 0, 1, 0, 32'h0000_0200, 32'h0, 1, 32'h8888_0000);
    do_txn(1, 0, 1, 0, 0, 32'h0000_0200, 32'h0102_0304, 1, 32'h0);
    do_txn(1, 0, 0, 0, 1, 32'h0000_0200, 32'h9999_9999, 1, 32'h0);
    check("sc_fail_ld", load_data, '0);
    for (int t = 0; t < 12; t++) begin
      do_txn(1, $urandom_range(0, 1), 1'b0, $urandom_range(0, 1), $urandom_range(0, 1),
             {28'h0000_020, $urandom_range(0, 1) == 1 ? 4'h4 : 4'h0}, $urandom,
             $urandom_range(1, 3), $urandom);
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end
endmodule
